// File: rtl/micro_sequencer.sv
// Purpose: next-state sequencer for the microprogrammed MIPS control unit (control-store address register).
// Latency: one cycle from microinstruction fields/conditions to State; all outputs registered.
// Backpressure: Stall freezes state, MOC-wait counter and sticky flags; MOC waits trap after MOC_TIMEOUT cycles.
module micro_sequencer #(
    parameter logic [6:0] RESET_STATE   = 7'd0,
    parameter logic [6:0] FETCH_STATE   = 7'd1,
    parameter logic [6:0] ILLEGAL_STATE = 7'd126,
    parameter logic [6:0] ERROR_STATE   = 7'd127,
    parameter int         MOC_TIMEOUT   = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [6:0] State_Sel,
    input  logic [1:0] Next_Sel,
    input  logic [6:0] Cr_Target,
    input  logic [1:0] Cond_Sel,
    input  logic       Cond_Inv,
    input  logic       False_Hold,
    input  logic       MOC,
    input  logic       Cond,
    input  logic       Stall,
    input  logic       Clr_Flags,
    output logic [6:0] State,
    output logic       Illegal_Op,
    output logic       Mem_Timeout
);

    // Counter value on the last permitted wait edge; reaching it traps instead of holding.
    localparam logic [7:0] WAIT_LAST = 8'(MOC_TIMEOUT - 1);

    logic [6:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;

    logic       cond_raw;
    logic       cond_true;
    logic       wait_edge;
    logic [6:0] state_inc;

    // Condition tester: select the raw condition, then optionally invert it.
    always_comb begin
        cond_raw = 1'b0;
        case (Cond_Sel)
            2'b00:   cond_raw = 1'b1;
            2'b01:   cond_raw = MOC;
            2'b10:   cond_raw = Cond;
            default: cond_raw = 1'b0;
        endcase
        cond_true = cond_raw ^ Cond_Inv;
        // A wait edge holds in place waiting for memory; only these edges advance the timeout counter.
        wait_edge = (Cond_Sel == 2'b01) && !cond_true && False_Hold;
        state_inc = state_q + 7'd1;
    end

    // Next-state selection: stall, then MOC timeout, then the normal sequencing choice.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        if (!Stall) begin
            // Clear first so that a set event on the same edge overrides it.
            if (Clr_Flags) begin
                illegal_d = 1'b0;
                timeout_d = 1'b0;
            end
            if (wait_edge) begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ERROR_STATE;
                    timeout_d  = 1'b1;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end else begin
                wait_cnt_d = 8'd0;
                if (cond_true) begin
                    case (Next_Sel)
                        2'b00: begin
                            if (State_Sel == 7'd0) begin
                                state_d   = ILLEGAL_STATE;
                                illegal_d = 1'b1;
                            end else begin
                                state_d = State_Sel;
                            end
                        end
                        2'b01:   state_d = state_inc;
                        2'b10:   state_d = Cr_Target;
                        default: state_d = FETCH_STATE;
                    endcase
                end else begin
                    state_d = False_Hold ? state_q : state_inc;
                end
            end
        end
    end

    // State, wait counter and sticky flags; reset takes effect immediately.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= RESET_STATE;
            wait_cnt_q <= 8'd0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    assign State       = state_q;
    assign Illegal_Op  = illegal_q;
    assign Mem_Timeout = timeout_q;

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Next-state sequencer for the microprogrammed MIPS control unit; sits directly downstream of the instruction state encoder.
- Holds the current control-state register that addresses the control-store ROM.
- Each cycle selects the next state from the encoder's state select, state+1, a microinstruction jump target, or the fetch state, gated by a condition tester (MOC, ALU condition).
- Adds a MOC-wait timeout and illegal-opcode trapping.

Parameters:
- RESET_STATE, 7'd0, state loaded on reset.
- FETCH_STATE, 7'd1, first state of the instruction fetch sequence.
- ILLEGAL_STATE, 7'd126, trap state when the encoder returns 0 at decode.
- ERROR_STATE, 7'd127, trap state on MOC timeout.
- MOC_TIMEOUT, 16, maximum cycles spent in a MOC-wait state; legal range 2..255.

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- State_Sel  in  7  decode target from the encoder; 0 means unrecognised instruction
- Next_Sel  in  2  microinstruction field: 00 encoder, 01 increment, 10 jump to Cr_Target, 11 fetch
- Cr_Target  in  7  microinstruction jump address
- Cond_Sel  in  2  microinstruction field: 00 always, 01 MOC, 10 Cond, 11 never
- Cond_Inv  in  1  invert the selected condition
- False_Hold  in  1  on a false condition: 1 holds the current state, 0 increments
- MOC  in  1  memory operation complete
- Cond  in  1  ALU branch condition
- Stall  in  1  freeze the sequencer
- Clr_Flags  in  1  synchronous clear of the sticky flags
- State  out  7  current control state (ROM address)
- Illegal_Op  out  1  sticky: an illegal instruction was decoded
- Mem_Timeout  out  1  sticky: a MOC wait timed out

Behaviour:
- Reset (async, Reset_n=0):
  - State=RESET_STATE, Illegal_Op=0, Mem_Timeout=0, wait counter=0.
  - Applies immediately, including mid-wait.
  - Outputs are registered; State changes only on a Clk rising edge after reset release.
- Condition evaluation (combinational):
  - raw is 1 for Cond_Sel=00, MOC for 01, Cond for 10, 0 for 11.
  - cond_true = raw XOR Cond_Inv.
- Target when cond_true:
  - 00: State_Sel, except State_Sel==0 gives ILLEGAL_STATE and sets Illegal_Op on that edge.
  - 01: State+1, modulo 128 (127 wraps to 0).
  - 10: Cr_Target.
  - 11: FETCH_STATE.
- When cond_true=0: next = False_Hold ? State : State+1 (modulo 128).
- MOC wait:
  - A wait edge is one with Cond_Sel=01, cond_true=0, False_Hold=1.
  - On a wait edge with counter<MOC_TIMEOUT-1: counter+1, State held.
  - On a wait edge with counter==MOC_TIMEOUT-1: State=ERROR_STATE, Mem_Timeout=1, counter=0.
  - Result: the state is occupied for exactly MOC_TIMEOUT cycles before the trap.
  - Any non-wait, non-stalled edge clears the counter.
- Priority per edge: Stall=1 freezes State, counter and flags (Clr_Flags is ignored while stalled); otherwise timeout check, then normal selection.
- Flags:
  - Clr_Flags=1 clears both flags on the edge.
  - If a set event occurs on the same edge, set wins.
- Latency: one cycle from inputs to State. No combinational path from inputs to outputs.
- Microinstruction fields are assumed valid every non-stalled cycle.

Test Plan:
- Reset and increment: release Reset_n, hold Next_Sel=01, Cond_Sel=00 -> State 0,1,2,3 on successive edges; drive Reset_n=0 mid-cycle -> State=0 immediately, without waiting for a clock edge.
- Decode dispatch: State_Sel=5, Next_Sel=00, Cond_Sel=00 -> State=5 next edge. Then State_Sel=0 -> State=126 and Illegal_Op=1, which stays set until Clr_Flags=1.
- MOC wait:
  - Fields Cond_Sel=01, False_Hold=1, Next_Sel=01, starting in state 20.
  - MOC=0 for 3 cycles, then 1 -> State stays 20 for 3 edges, then 21; Mem_Timeout stays 0.
- MOC timeout: same fields as the MOC wait test, MOC held 0 -> State=20 for exactly 16 cycles, then 127 with Mem_Timeout=1. Re-entering a wait afterwards starts again from a counter of 0.
- Branch:
  - Cond_Sel=10, Next_Sel=10, Cr_Target=40, False_Hold=0, State=10.
  - Cond=1 -> 40; Cond=0 -> 11. With Cond_Inv=1 both results swap.
- Wrap and stall:
  - State=127, Next_Sel=01 -> 0.
  - Stall=1 for 4 cycles during a MOC wait -> State and counter frozen; the timeout occurs 4 cycles later than it would without the stall.
